// File: rtl/hdmi_pkg.sv
// Shared widths, BCH polynomial and serial parity step for the HDMI data-island
// packet assembler and its reference model.
package hdmi_pkg;

  localparam int unsigned SLOTS     = 32;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SLOT_W    = 9;
  localparam int unsigned HDR_BITS  = 24;
  localparam int unsigned SUB_BITS  = 56;
  localparam int unsigned SUB_SLOTS = 28;
  localparam int unsigned NUM_SUB   = 4;
  localparam int unsigned PAR_W     = 8;

  localparam logic [PAR_W-1:0] BCH_POLY = 8'h83;

  typedef logic [NUM_SUB-1:0][SUB_BITS-1:0] sub_arr_t;

  // One LSB-first BCH step of G(x)=1+x^6+x^7+x^8.
  function automatic logic [PAR_W-1:0] bch_step(input logic [PAR_W-1:0] p, input logic b);
    return {1'b0, p[PAR_W-1:1]} ^ ((b ^ p[0]) ? BCH_POLY : PAR_W'(0));
  endfunction

endpackage

// File: rtl/hdmi_bch_ecc.sv
// Serial BCH parity register consuming W data bits per enabled cycle (bit 0 first).
module hdmi_bch_ecc
  import hdmi_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [W-1:0]     i_bits,
  output logic [PAR_W-1:0] o_parity
);

  logic [PAR_W-1:0] r_par;
  logic [PAR_W-1:0] w_next;

  // A clear in the same cycle as a step restarts the chain from zero.
  always_comb begin
    w_next = i_clr ? '0 : r_par;
    for (int k = 0; k < int'(W); k++) begin
      w_next = bch_step(w_next, i_bits[k]);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_par <= '0;
    end else if (i_en) begin
      r_par <= w_next;
    end else if (i_clr) begin
      r_par <= '0;
    end
  end

  assign o_parity = r_par;

endmodule

// File: rtl/hdmi_packet_assembler.sv
// Serialises a 24-bit header plus four 56-bit subpackets into 32 nine-bit
// data-island slots, appending BCH parity on the fly.
module hdmi_packet_assembler
  import hdmi_pkg::*;
(
  input  logic                clk_pixel,
  input  logic                reset_n,
  input  logic                data_island_period,
  input  logic [HDR_BITS-1:0] header,
  input  sub_arr_t            sub,
  output logic [CNT_W-1:0]    counter,
  output logic [SLOT_W-1:0]   packet_data,
  output logic                packet_load,
  output logic                packet_done
);

  logic [CNT_W-1:0]    r_counter;
  logic [HDR_BITS-1:0] r_header;
  sub_arr_t            r_sub;
  logic [SLOT_W-1:0]   r_data;
  logic                r_load;
  logic                r_done;

  logic                w_first;
  logic                w_capture;
  logic                w_hdr_data;
  logic                w_sub_data;
  logic [HDR_BITS-1:0] w_hdr;
  sub_arr_t            w_sub;
  logic [SLOTS-1:0]    w_hdr_pad;
  logic                w_hdr_bit;
  logic [PAR_W-1:0]    w_hdr_par;
  logic [SLOT_W-1:0]   w_slot;
  logic [1:0]          w_sub_bits [NUM_SUB];
  logic [1:0]          w_sub_out  [NUM_SUB];

  assign w_first    = (r_counter == '0);
  assign w_capture  = data_island_period && w_first;
  assign w_hdr_data = (r_counter < CNT_W'(HDR_BITS));
  assign w_sub_data = (r_counter < CNT_W'(SUB_SLOTS));

  // Slot 0 is built from the live inputs; later slots from the snapshot.
  assign w_hdr     = w_first ? header : r_header;
  assign w_sub     = w_first ? sub : r_sub;
  assign w_hdr_pad = {(SLOTS - HDR_BITS)'(0), w_hdr};
  assign w_hdr_bit = w_hdr_pad[r_counter];

  hdmi_bch_ecc #(.W(1)) u_hdr_ecc (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .i_clr     (w_capture),
    .i_en      (data_island_period && w_hdr_data),
    .i_bits    (w_hdr_bit),
    .o_parity  (w_hdr_par)
  );

  for (genvar gi = 0; gi < int'(NUM_SUB); gi++) begin : g_sub
    logic [2*SLOTS-1:0] w_pad;
    logic [PAR_W-1:0]   w_par;

    assign w_pad          = {(2*SLOTS - SUB_BITS)'(0), w_sub[gi]};
    assign w_sub_bits[gi] = w_pad[{r_counter, 1'b0} +: 2];

    hdmi_bch_ecc #(.W(2)) u_sub_ecc (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .i_clr     (w_capture),
      .i_en      (data_island_period && w_sub_data),
      .i_bits    (w_sub_bits[gi]),
      .o_parity  (w_par)
    );

    // Parity slots 28..31 map to pair index counter[1:0].
    assign w_sub_out[gi] = w_sub_data ? w_sub_bits[gi] : w_par[{r_counter[1:0], 1'b0} +: 2];
  end

  // Header parity slots 24..31 map to bit index counter[2:0].
  always_comb begin
    w_slot    = '0;
    w_slot[0] = w_hdr_data ? w_hdr_bit : w_hdr_par[r_counter[2:0]];
    for (int i = 0; i < int'(NUM_SUB); i++) begin
      w_slot[1+i] = w_sub_out[i][0];
      w_slot[5+i] = w_sub_out[i][1];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_header  <= '0;
      r_sub     <= '0;
      r_data    <= '0;
      r_load    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      if (data_island_period) begin
        r_counter <= r_counter + CNT_W'(1);
        r_data    <= w_slot;
        r_load    <= w_first;
        r_done    <= (r_counter == CNT_W'(SLOTS - 1));
        if (w_first) begin
          r_header <= header;
          r_sub    <= sub;
        end
      end
    end
  end

  assign counter     = r_counter;
  assign packet_data = r_data;
  assign packet_load = r_load;
  assign packet_done = r_done;

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
// Scoreboard bench for hdmi_packet_assembler: driver pushes per-cycle expectations,
// monitor pops and compares one edge later.
module tb_hdmi_packet_assembler;
  import hdmi_pkg::*;

  typedef struct packed {
    logic [4:0] cnt;
    logic [8:0] data;
    logic       load;
    logic       done;
  } exp_t;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        data_island_period;
  logic [23:0] header;
  sub_arr_t    sub;
  logic [4:0]  counter;
  logic [8:0]  packet_data;
  logic        packet_load;
  logic        packet_done;

  exp_t        scb[$];
  exp_t        m_exp;
  exp_t        m_got;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [8:0]  slots [32];
  logic [4:0]  m_cnt;
  logic [8:0]  m_data;
  logic        hand_mode;
  logic [7:0]  hand_par;
  sub_arr_t    avi_sub;

  hdmi_packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .counter            (counter),
    .packet_data        (packet_data),
    .packet_load        (packet_load),
    .packet_done        (packet_done)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Whole-packet reference: batch parity over all data bits, then slot mapping.
  function automatic void build(input logic [23:0] h, input sub_arr_t s);
    logic [7:0] hp;
    logic [7:0] sp [4];
    hp = '0;
    for (int k = 0; k < 24; k++) hp = bch_step(hp, h[k]);
    for (int i = 0; i < 4; i++) begin
      sp[i] = '0;
      for (int k = 0; k < 56; k++) sp[i] = bch_step(sp[i], s[i][k]);
    end
    for (int c = 0; c < 32; c++) begin
      slots[c]    = '0;
      slots[c][0] = (c < 24) ? h[c] : hp[c-24];
      for (int i = 0; i < 4; i++) begin
        slots[c][1+i] = (c < 28) ? s[i][2*c]   : sp[i][2*(c-28)];
        slots[c][5+i] = (c < 28) ? s[i][2*c+1] : sp[i][2*(c-28)+1];
      end
    end
  endfunction

  // Hand-derived packet for header=1, subs=0: header ECC is 8'h4A.
  function automatic void build_hand();
    for (int c = 0; c < 32; c++) begin
      slots[c]    = '0;
      slots[c][0] = (c < 24) ? (c == 0) : hand_par[c-24];
    end
  endfunction

  task automatic tick(input logic dip, input logic rst);
    exp_t e;
    data_island_period = dip;
    reset_n            = rst;
    e.load = 1'b0;
    e.done = 1'b0;
    if (!rst) begin
      m_cnt  = '0;
      m_data = '0;
    end else if (dip) begin
      if (m_cnt == 5'd0) begin
        if (hand_mode) build_hand();
        else build(header, sub);
      end
      m_data = slots[m_cnt];
      e.load = (m_cnt == 5'd0);
      e.done = (m_cnt == 5'd31);
      m_cnt  = m_cnt + 5'd1;
    end
    e.cnt  = m_cnt;
    e.data = m_data;
    scb.push_back(e);
    @(negedge clk_pixel);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b1);
  endtask

  always @(posedge clk_pixel) begin
    #1;
    if (scb.size() > 0) begin
      m_exp = scb.pop_front();
      m_got = {counter, packet_data, packet_load, packet_done};
      n_tests++;
      if (m_got !== m_exp) begin
        n_fail++;
        $display("FAIL slot t=%0t: got cnt=%0d data=%h load=%b done=%b, expected cnt=%0d data=%h load=%b done=%b",
                 $time, m_got.cnt, m_got.data, m_got.load, m_got.done,
                 m_exp.cnt, m_exp.data, m_exp.load, m_exp.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset_n            = 1'b0;
    data_island_period = 1'b0;
    header             = '0;
    sub                = '0;
    hand_mode          = 1'b0;
    hand_par           = 8'h4A;
    m_cnt              = '0;
    m_data             = '0;
    avi_sub[0] = 56'h00_00_00_00_19_10_37;
    avi_sub[1] = 56'h00_00_00_00_00_00_00;
    avi_sub[2] = 56'hA5_5A_C3_3C_0F_F0_81;
    avi_sub[3] = 56'h12_34_56_78_9A_BC_DE;
    @(negedge clk_pixel);

    // Reset state, then an idle cycle
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);

    // All-zero packet
    run(32);

    // Single header bit, hand-computed ECC
    header    = 24'h000001;
    hand_mode = 1'b1;
    run(32);
    hand_mode = 1'b0;

    // AVI InfoFrame packet, back-to-back
    header = 24'h0D0282;
    sub    = avi_sub;
    run(32);

    // Mid-packet pause after slot 10
    run(11);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
    run(21);

    // Input change after capture at slot 3
    header = 24'hA1B2C3;
    run(3);
    header = 24'h5E6F70;
    sub[1] = 56'hFF_EE_DD_CC_BB_AA_99;
    run(29);
    run(32);

    // Reset at slot 17, then a fresh packet
    header = 24'h0D0282;
    sub    = avi_sub;
    run(17);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    run(32);
    tick(1'b0, 1'b1);

    @(posedge clk_pixel);
    #2;
    n_tests++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
